// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg
// Handshaked pipeline-stage register placed between two pipeline stages.
// With SKID_EN=1 it holds up to two entries (main + skid) so that up_ready
// comes straight from a flop and the downstream stall path is cut. With
// SKID_EN=0 it is a single register with a combinational up_ready.
// Flush empties the stage and restores BUBBLE_DATA. Two saturating counters
// record stall and bubble cycles.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// Once dn_valid is high it stays high until dn_ready is seen, except on
// flush or reset. dn_data is stable while dn_valid && !dn_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      squash all held entries this cycle
//   up_valid   upstream payload valid
//   up_ready   stage can accept a payload
//   up_data    upstream payload
//   dn_valid   head entry valid
//   dn_ready   downstream accepts
//   dn_data    head payload, BUBBLE_DATA when !dn_valid
//   occupancy  number of held entries (0..2)
//   stall_cnt  cycles with dn_valid && !dn_ready (saturating)
//   bubble_cnt cycles with dn_ready && !dn_valid (saturating)
//   clr_cnt    synchronous clear of both counters
module pipe_stage_skid_reg #(
    parameter int unsigned       DATA_W      = 256,
    parameter bit                SKID_EN     = 1'b1,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = {DATA_W{1'b0}},
    parameter int unsigned       CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    input  logic              clr_cnt
);

    // Encoding equals the number of held entries, so occupancy is the state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_nxt;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_nxt;
    logic              full_q;
    logic              up_fire;
    logic              dn_fire;

    // With the skid enabled up_ready is a pure flop output; without it the
    // single register may refill in the same cycle it drains.
    assign up_ready = SKID_EN ? !full_q : (!dn_valid || dn_ready);
    assign up_fire  = up_valid && up_ready;
    assign dn_fire  = dn_valid && dn_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= BUBBLE_DATA;
            skid_q <= BUBBLE_DATA;
            full_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
            full_q <= (state_nxt == FULL);
        end
    end

    // Next-state logic; flush overrides every transition and discards any
    // payload fired into the stage in the same cycle.
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            state_nxt = EMPTY;
            main_nxt  = BUBBLE_DATA;
            skid_nxt  = BUBBLE_DATA;
        end else begin
            case (state)
                EMPTY: begin
                    if (up_fire) begin
                        state_nxt = ONE;
                        main_nxt  = up_data;
                    end
                end
                ONE: begin
                    if (up_fire && dn_fire) begin
                        main_nxt = up_data;
                    end else if (up_fire) begin
                        // Only reachable with SKID_EN=1.
                        state_nxt = FULL;
                        skid_nxt  = up_data;
                    end else if (dn_fire) begin
                        state_nxt = EMPTY;
                        main_nxt  = BUBBLE_DATA;
                    end
                end
                FULL: begin
                    // up_ready is low here, so only a drain can happen.
                    if (dn_fire) begin
                        state_nxt = ONE;
                        main_nxt  = skid_q;
                        skid_nxt  = BUBBLE_DATA;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    main_nxt  = BUBBLE_DATA;
                    skid_nxt  = BUBBLE_DATA;
                end
            endcase
        end
    end

    // Outputs; the mux keeps dn_data at the bubble payload whenever empty.
    always_comb begin
        dn_valid  = (state != EMPTY);
        dn_data   = dn_valid ? main_q : BUBBLE_DATA;
        occupancy = state;
    end

    // Saturating performance counters; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (dn_valid && !dn_ready && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (dn_ready && !dn_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
Parametrised, handshaked pipeline-stage register. It replaces the fixed, enable-driven ID/EX-style latch used between stages with a valid/ready interface.
- Optional 2-entry skid buffer, so upstream ready is driven from a register and the global stall path is broken.
- Flush squashes the stage contents into a configurable bubble payload.
- Saturating stall and bubble performance counters.
- Instantiated once per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB), with the stage's packed control/data bundle as payload.

Parameters:
- DATA_W, 256, payload width in bits (packed stage bundle).
- SKID_EN, 1, 1 = 2-entry skid with registered up_ready; 0 = single register with combinational up_ready.
- BUBBLE_DATA, {DATA_W{1'b0}}, payload driven on dn_data when no valid entry exists (e.g. a NOP encoding in the debug-instr field).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  squash all held entries this cycle.
- up_valid  in  1  upstream payload valid.
- up_ready  out  1  stage can accept; up fire = up_valid & up_ready.
- up_data  in  DATA_W  upstream payload.
- dn_valid  out  1  head entry valid.
- dn_ready  in  1  downstream accepts; dn fire = dn_valid & dn_ready.
- dn_data  out  DATA_W  head payload, or BUBBLE_DATA when !dn_valid.
- occupancy  out  2  entries held (0..2; max 1 when SKID_EN=0).
- stall_cnt  out  CNT_W  cycles with dn_valid & !dn_ready.
- bubble_cnt  out  CNT_W  cycles with dn_ready & !dn_valid.
- clr_cnt  in  1  synchronous clear of both counters.

Behaviour:

Reset (async assert, sync release):
- All entries invalid; main and skid data = BUBBLE_DATA.
- dn_valid=0, occupancy=0, counters=0.
- up_ready=1 on the first edge after release.

State (SKID_EN=1): EMPTY, ONE (main valid), FULL (main + skid valid).
- EMPTY: up fire -> ONE, main<=up_data.
- ONE:
  - up fire & dn fire -> ONE, main<=up_data.
  - up fire only -> FULL, skid<=up_data.
  - dn fire only -> EMPTY, main<=BUBBLE_DATA.
- FULL:
  - up_ready=0.
  - dn fire -> ONE, main<=skid, skid<=BUBBLE_DATA.
- up_ready = (state != FULL), taken directly from a state register. No combinational path from dn_ready.

SKID_EN=0:
- Single main entry.
- up_ready = !dn_valid | dn_ready (combinational).
- Up fire loads main. Dn fire without up fire invalidates it.

Timing and ordering:
- Latency: payload accepted at edge N is visible on dn_data/dn_valid after edge N. Throughput is 1 per cycle sustained.
- Order is strictly FIFO; the skid entry is never presented before main.

flush:
- Next state is EMPTY regardless of up_valid/dn_ready. All data <= BUBBLE_DATA.
- A simultaneous up fire is discarded. up_ready is still driven per the current state, so the upstream stage sees it as consumed and must itself be flushed.
- A simultaneous dn fire completes downstream.
- flush has priority over every other transition. It does not affect the counters.

Counters:
- Evaluated every cycle from the current dn_valid/dn_ready.
- Saturate at 2^CNT_W-1 with no wrap.
- clr_cnt wins over increment: the counter becomes 0 that cycle.

Boundary conditions:
- dn_ready toggling while FULL never loses or duplicates an entry.
- up_valid with up_ready=0 has no effect.
- Reset mid-transfer discards all entries immediately (async).
- dn_data never shows stale payload after an entry is invalidated; it shows BUBBLE_DATA.

Test Plan:
1. SKID_EN=1, DATA_W=32. Stream 0x11,0x22,0x33 on consecutive cycles with dn_ready=1 -> dn_data 0x11,0x22,0x33 one cycle later, back-to-back; occupancy stays 1; bubble_cnt counts only the leading idle cycles.
2. Backpressure: dn_ready=0 while sending 0xA1,0xA2,0xA3 -> after two accepts up_ready=0, occupancy=2, 0xA3 held upstream; raise dn_ready -> output order 0xA1,0xA2,0xA3; stall_cnt equals the number of dn_ready=0 cycles with dn_valid=1.
3. Flush in FULL with up_valid=1 (0xB3) and dn_ready=0 -> next cycle dn_valid=0, dn_data=BUBBLE_DATA (set to 0x13), occupancy=0, 0xB3 never appears.
4. SKID_EN=0, dn_ready=0 with main valid -> up_ready=0 in the same cycle; raise dn_ready -> up_ready=1 combinationally and a new payload replaces main at the next edge.
5. CNT_W=4: hold dn_valid=1, dn_ready=0 for 20 cycles -> stall_cnt saturates at 15. Pulse clr_cnt together with a stall cycle -> stall_cnt=0.
6. Assert rst asynchronously mid-stream, between edges -> dn_valid, occupancy and counters go to 0 immediately; up_ready=1 after release.
